instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the core's immediate/field decode path.
- Accepts a format select, register fields, funct fields and a full 32-bit signed immediate value.
- Range-checks the immediate, packs a 32-bit instruction word and emits it with a sequential word address for instruction-memory loading.
- Used by the test program loader and self-modifying-code tests; ready/valid on both sides with a 2-entry skid buffer.

Parameters:
- ADDR_W, 10, width of the output word address counter.
- BASE_ADDR, 0, address assigned after reset or restart.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- restart  input  1  synchronous pulse; reloads the address counter and clears err_cnt
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  0=LOAD(0000011), 1=I-ALU(0010011), 2=SHIFT(0010011), 3=STORE(0100011), 4=BRANCH(1100011), 5-7 invalid
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7; SHIFT format only
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  immediate as a signed byte value (branch value is the byte offset)
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  encoded instruction word
- out_addr  output  ADDR_W  word address for out_instr
- out_err  output  1  request was illegal; out_instr is a NOP
- err_cnt  output  8  saturating count of accepted illegal requests

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_cnt=0, in_ready=1, skid buffer empty, address counter=BASE_ADDR.
- Encoding, with fields packed in standard RV32 positions:
  - LOAD, I-ALU: instr[31:20]=imm[11:0].
  - SHIFT: instr[31:25]=funct7, instr[24:20]=imm[4:0].
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - rd is used only for LOAD, I-ALU and SHIFT; rs2 only for STORE and BRANCH.
- Legality; any failure raises the error flag:
  - LOAD, I-ALU, STORE: imm[31:11] all equal (fits signed 12-bit).
  - I-ALU: funct3 not 001 or 101; those go through SHIFT.
  - SHIFT: imm[31:5]==0; funct3 must be 001 or 101; funct7 must be 0000000, or 0100000 only with funct3=101.
  - LOAD: funct3 must be one of 000, 001, 010, 100, 101.
  - STORE: funct3 must be one of 000, 001, 010.
  - BRANCH: imm[31:12] all equal, imm[0]==0, funct3 not 010 or 011.
  - in_fmt 5-7 is always an error.
- Error result: out_instr=0x00000013 (addi x0,x0,0), out_err=1, err_cnt increments and saturates at 255.
- Addressing:
  - The counter value is attached at acceptance; the counter increments by 1 per accepted request and wraps modulo 2^ADDR_W.
  - Illegal requests still consume an address.
- Restart:
  - Counter becomes BASE_ADDR and err_cnt becomes 0.
  - If a request is accepted in the same cycle, it gets BASE_ADDR and the counter becomes BASE_ADDR+1.
  - If that same-cycle request is illegal, err_cnt=1.
  - Words already in flight keep their addresses.
- Pipeline:
  - Latency 1: a word accepted in cycle N is presented in cycle N+1 when the output is free.
  - in_ready is registered and equals "skid entry empty".
  - When out_valid && !out_ready and a new request arrives, it is encoded into the skid entry and in_ready deasserts next cycle.
  - When the output drains, the skid entry moves to the output register.
  - Order is strictly preserved; no word is lost or duplicated.
  - Output registers are stable while out_valid && !out_ready.
- Throughput: one word per cycle while out_ready is held high.

Test Plan:
- fmt=1, f3=000, rd=1, rs1=0, imm=0xFFFFFFFF after reset -> next cycle out_instr=0xFFF00093, out_addr=0, out_err=0.
- fmt=3, f3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423; then fmt=4, f3=000, rs1=0, rs2=0, imm=0xFFFFFFFC -> 0xFE000EE3 at addr 1.
- fmt=2, f3=101, f7=0100000, rd=5, rs1=6, imm=3 -> 0x40335293; same with imm=32 -> 0x00000013, out_err=1, err_cnt=1.
- Illegal cases: fmt=4 imm=3, fmt=1 imm=2048, fmt=6 -> each yields NOP with out_err=1; err_cnt=3; 260 illegal requests total -> err_cnt=255.
- Backpressure: out_ready=0 while 3 back-to-back requests -> 2 accepted, in_ready=0 with 3rd held; release -> words emitted in order, addrs 0,1,2, none duplicated.
- restart with a simultaneous accept -> that word at BASE_ADDR, next at BASE_ADDR+1; rst_n low mid-stream -> out_valid=0 immediately, addr restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: range-checks fields, packs a word, tags it with a sequential word address.
// Latency 1 cycle; a 2-entry skid (output reg + skid entry) keeps in_ready registered under out_ready backpressure.
module instr_encoder #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    logic              out_valid_q, out_err_q, skid_vld_q, skid_err_q;
    logic [31:0]       out_instr_q, skid_instr_q;
    logic [ADDR_W-1:0] out_addr_q, skid_addr_q, addr_cnt_q, addr_cnt_d, acc_addr;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic        fits12, fits13, enc_err;
    logic [31:0] enc_word, enc_instr;
    logic        acc, out_free;

    assign acc      = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        fits12   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
        fits13   = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
        enc_err  = 1'b0;
        enc_word = NOP_INSTR;
        case (in_fmt)
            3'd0: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                enc_err  = !fits12 || (in_funct3 == 3'b011) || (in_funct3 == 3'b110)
                           || (in_funct3 == 3'b111);
            end
            3'd1: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
                enc_err  = !fits12 || (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
            end
            3'd2: begin
                enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
                // Arithmetic right shift (funct7=0100000) exists only for funct3=101.
                enc_err  = (in_imm[31:5] != '0)
                           || !((in_funct3 == 3'b001) || (in_funct3 == 3'b101))
                           || !((in_funct7 == 7'b0000000)
                                || ((in_funct7 == 7'b0100000) && (in_funct3 == 3'b101)));
            end
            3'd3: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
                enc_err  = !fits12 || (in_funct3 > 3'b010);
            end
            3'd4: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OP_BRANCH};
                enc_err  = !fits13 || in_imm[0] || (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
            end
            default: enc_err = 1'b1;
        endcase
        enc_instr = enc_err ? NOP_INSTR : enc_word;
    end

    // A request accepted together with restart takes BASE_ADDR and restarts the error count.
    always_comb begin
        acc_addr   = restart ? BASE_ADDR : addr_cnt_q;
        addr_cnt_d = acc ? acc_addr + 1'b1 : acc_addr;
        err_cnt_d  = restart ? 8'd0 : err_cnt_q;
        if (acc && enc_err && (err_cnt_d != 8'hFF)) begin
            err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_addr_q   <= BASE_ADDR;
            out_err_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_addr_q  <= BASE_ADDR;
            skid_err_q   <= 1'b0;
            addr_cnt_q   <= BASE_ADDR;
            err_cnt_q    <= '0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (out_free) begin
                if (skid_vld_q) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= skid_instr_q;
                    out_addr_q  <= skid_addr_q;
                    out_err_q   <= skid_err_q;
                    skid_vld_q  <= 1'b0;
                end else if (acc) begin
                    out_valid_q <= 1'b1;
                    out_instr_q <= enc_instr;
                    out_addr_q  <= acc_addr;
                    out_err_q   <= enc_err;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (acc) begin
                skid_vld_q   <= 1'b1;
                skid_instr_q <= enc_instr;
                skid_addr_q  <= acc_addr;
                skid_err_q   <= enc_err;
            end
        end
    end

    assign in_ready  = !skid_vld_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, legality, addressing, backpressure, restart and reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        in_valid  = 1'b0;
        restart   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        in_fmt    = v.fmt;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_valid  = 1'b1;
    endtask

    // Presents one request, waits (bounded) until accepted; returns at posedge+1 after acceptance.
    task automatic send(input vec_t v);
        int k;
        drive(v);
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_err, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags: valid/err/ready=%b required 001", {out_valid, out_err, in_ready});
        end
        checks++;
        if (out_instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h required 00000000", out_instr);
        end
        checks++;
        if (out_addr !== 10'd0 || err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counters: addr=%0d err_cnt=%0d required 0/0", out_addr, err_cnt);
        end
    endtask

    task automatic test_legal();
        vec_t v[$];
        do_reset();
        v.push_back('{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093});
        v.push_back('{3'd3, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423});
        v.push_back('{3'd4, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3});
        v.push_back('{3'd2, 3'b101, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293});
        v.push_back('{3'd0, 3'b010, 7'h00, 5'd3, 5'd2, 5'd0, 32'hFFFFFFF8, 32'hFF812183});
        v.push_back('{3'd2, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd31,       32'h01F09093});
        v.push_back('{3'd1, 3'b000, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2047,     32'h7FF00113});
        v.push_back('{3'd1, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000013});
        v.push_back('{3'd4, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3});
        foreach (v[i]) begin
            send(v[i]);
            checks++;
            if ({out_valid, out_err, out_addr, out_instr} !== {1'b1, 1'b0, 10'(i), v[i].exp}) begin
                errors++;
                $display("FAIL legal[%0d]: valid=%b err=%b addr=%0d instr=%h required 1 0 %0d %h",
                         i, out_valid, out_err, out_addr, out_instr, i, v[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        vec_t bad;
        do_reset();
        v.push_back('{3'd2, 3'b101, 7'h20, 5'd5, 5'd6, 5'd0, 32'd32,       32'h13});
        v.push_back('{3'd4, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h13});
        v.push_back('{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h13});
        v.push_back('{3'd6, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,        32'h13});
        v.push_back('{3'd1, 3'b001, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1,        32'h13});
        v.push_back('{3'd2, 3'b001, 7'h20, 5'd1, 5'd0, 5'd0, 32'd1,        32'h13});
        v.push_back('{3'd0, 3'b011, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4,        32'h13});
        v.push_back('{3'd3, 3'b011, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4,        32'h13});
        v.push_back('{3'd4, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4,        32'h13});
        v.push_back('{3'd3, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF, 32'h13});
        foreach (v[i]) begin
            send(v[i]);
            checks++;
            if ({out_valid, out_err, out_addr, out_instr, err_cnt} !==
                {1'b1, 1'b1, 10'(i), 32'h00000013, 8'(i + 1)}) begin
                errors++;
                $display("FAIL illegal[%0d]: valid=%b err=%b addr=%0d instr=%h err_cnt=%0d required 1 1 %0d 00000013 %0d",
                         i, out_valid, out_err, out_addr, out_instr, err_cnt, i, i + 1);
            end
        end
        bad = '{3'd7, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h13};
        for (int n = 10; n < 255; n++) send(bad);
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++; $display("FAIL err_cnt_255: got %0d required 255", err_cnt);
        end
        for (int n = 255; n < 260; n++) send(bad);
        checks++;
        if (err_cnt !== 8'd255 || out_addr !== 10'd259) begin
            errors++;
            $display("FAIL err_cnt_saturate: err_cnt=%0d addr=%0d required 255 259", err_cnt, out_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_i[$];
        logic [9:0]  got_a[$];
        logic        acc;
        vec_t a, b, c;
        do_reset();
        a = '{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093};
        b = '{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2, 32'h00200093};
        c = '{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 32'h00300093};
        out_ready = 1'b0;
        drive(a); @(posedge clk); #1;
        drive(b); @(posedge clk); #1;
        drive(c);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd0, a.exp}) begin
            errors++;
            $display("FAIL bp_hold: valid=%b addr=%0d instr=%h required 1 0 %h", out_valid, out_addr, out_instr, a.exp);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                got_i.push_back(out_instr);
                got_a.push_back(out_addr);
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (got_i.size() != 3) begin
            errors++; $display("FAIL bp_count: got %0d words required 3", got_i.size());
        end else begin
            checks++;
            if ({got_i[0], got_a[0], got_i[1], got_a[1], got_i[2], got_a[2]} !==
                {a.exp, 10'd0, b.exp, 10'd1, c.exp, 10'd2}) begin
                errors++;
                $display("FAIL bp_order: got %h@%0d %h@%0d %h@%0d required %h@0 %h@1 %h@2",
                         got_i[0], got_a[0], got_i[1], got_a[1], got_i[2], got_a[2], a.exp, b.exp, c.exp);
            end
        end
    endtask

    task automatic test_restart();
        vec_t good, bad;
        do_reset();
        good = '{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093};
        bad  = '{3'd5, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'h13};
        send(bad);
        send(good);
        send(good);
        restart = 1'b1;
        send(bad);
        restart = 1'b0;
        checks++;
        if ({out_err, out_addr, err_cnt} !== {1'b1, 10'd0, 8'd1}) begin
            errors++;
            $display("FAIL restart_same_cycle: err=%b addr=%0d err_cnt=%0d required 1 0 1", out_err, out_addr, err_cnt);
        end
        send(good);
        checks++;
        if ({out_err, out_addr, out_instr} !== {1'b0, 10'd1, good.exp}) begin
            errors++;
            $display("FAIL restart_next: err=%b addr=%0d instr=%h required 0 1 %h", out_err, out_addr, out_instr, good.exp);
        end
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        send(good);
        checks++;
        if ({out_addr, err_cnt} !== {10'd0, 8'd0}) begin
            errors++; $display("FAIL restart_idle: addr=%0d err_cnt=%0d required 0 0", out_addr, err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        vec_t good;
        do_reset();
        good = '{3'd1, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7, 32'h00700093};
        out_ready = 1'b0;
        send(good);
        drive(good);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_addr} !== {1'b0, 1'b1, 10'd0}) begin
            errors++;
            $display("FAIL reset_async: valid=%b ready=%b addr=%0d required 0 1 0", out_valid, in_ready, out_addr);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(good);
        checks++;
        if ({out_valid, out_addr, out_instr} !== {1'b1, 10'd0, good.exp}) begin
            errors++;
            $display("FAIL reset_restart_addr: valid=%b addr=%0d instr=%h required 1 0 %h", out_valid, out_addr, out_instr, good.exp);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
